// File: rtl/impl_selftest_ctrl.sv
// Self-test sequencer: sweeps all four {a,b} vectors into a 2-input cell and grades its output.
// Sweep latency: o_done rises 4*(SETTLE_CYCLES+1)+1 edges after the edge that accepted start.
// No backpressure: i_start is taken only in IDLE/DONE and ignored while the sweep runs.
module impl_selftest_ctrl #(
   parameter int         SETTLE_CYCLES = 2,        // 1..15 cycles a vector is held before sampling
   parameter logic [3:0] EXPECTED      = 4'b1011   // expected cell output, bit k for vector k={a,b}
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_start,
   output logic       o_a,
   output logic       o_b,
   input  logic       i_c,
   output logic       o_busy,
   output logic       o_done,
   output logic       o_pass,
   output logic [3:0] o_result,
   output logic [2:0] o_err_cnt,
   output logic [1:0] o_first_err_idx
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   // Settle counter counts down to zero, so the hold time is SETTLE_CYCLES+1 cycles per vector
   localparam logic [3:0] CNT_RELOAD = 4'(SETTLE_CYCLES - 1);

   state_t     state_q, state_d;
   logic [1:0] idx_q, idx_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] result_q, result_d;
   logic [2:0] err_cnt_q, err_cnt_d;
   logic [1:0] first_err_q, first_err_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;

   // Next-state and registered-output computation for the sweep sequencer
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      result_d    = result_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      done_d      = done_q;
      pass_d      = pass_q;

      case (state_q)
         IDLE, DONE: begin
            if (i_start) begin
               // Restart: vector 00 goes out immediately and every result field is cleared
               idx_d       = 2'd0;
               cnt_d       = CNT_RELOAD;
               result_d    = 4'd0;
               err_cnt_d   = 3'd0;
               first_err_d = 2'd0;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               state_d     = SETTLE;
            end else if (state_q == DONE) begin
               // Done/pass follow one cycle after the final sample, once the counts are final
               done_d = 1'b1;
               pass_d = (err_cnt_q == 3'd0);
            end
         end
         SETTLE: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               state_d = SAMPLE;
            end
         end
         SAMPLE: begin
            result_d[idx_q] = i_c;
            if (i_c != EXPECTED[idx_q]) begin
               err_cnt_d = err_cnt_q + 3'd1;
               if (err_cnt_q == 3'd0) begin
                  first_err_d = idx_q;
               end
            end
            if (idx_q == 2'd3) begin
               // Last vector stays on the cell while in DONE
               state_d = DONE;
            end else begin
               idx_d   = idx_q + 2'd1;
               cnt_d   = CNT_RELOAD;
               state_d = SETTLE;
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
   end

   // State register with asynchronous abort on reset
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q     <= IDLE;
         idx_q       <= 2'd0;
         cnt_q       <= 4'd0;
         result_q    <= 4'd0;
         err_cnt_q   <= 3'd0;
         first_err_q <= 2'd0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         result_q    <= result_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
      end
   end

   // Every output comes straight from a flop; i_c never reaches an output combinationally
   assign o_a             = idx_q[1];
   assign o_b             = idx_q[0];
   assign o_busy          = busy_q;
   assign o_done          = done_q;
   assign o_pass          = pass_q;
   assign o_result        = result_q;
   assign o_err_cnt       = err_cnt_q;
   assign o_first_err_idx = first_err_q;

endmodule

// File: tb/tb_impl_selftest_ctrl.sv
// Bench for impl_selftest_ctrl: two instances (settle 2 and settle 1) driving modelled cells.
// Expected sweeps are queued at start; a negedge monitor grades timing, vectors and results.
// Cells are truth-table models, so any 2-input function (impl, stuck-at, random) can be tried.
module tb_impl_selftest_ctrl;

   localparam logic [3:0] EXP = 4'b1011;

   typedef struct {
      int         start_cyc;
      logic [3:0] res;
      int         err;
      int         first;
      bit         pass;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic            start;
   logic [1:0][3:0] tt;
   logic [1:0]      a_w, b_w, c_w, busy_w, done_w, pass_w;
   logic [1:0][3:0] res_w;
   logic [1:0][2:0] errc_w;
   logic [1:0][1:0] fidx_w;

   int   cyc = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   rd0 = 0;
   int   rd1 = 0;
   int   checks = 0;
   int   errors = 0;
   logic [1:0] prev_done = 2'b00;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      impl_selftest_ctrl #(
         .SETTLE_CYCLES ((g == 0) ? 2 : 1),
         .EXPECTED      (EXP)
      ) u_dut (
         .i_clk           (clk),
         .i_rst           (rst),
         .i_start         (start),
         .o_a             (a_w[g]),
         .o_b             (b_w[g]),
         .i_c             (c_w[g]),
         .o_busy          (busy_w[g]),
         .o_done          (done_w[g]),
         .o_pass          (pass_w[g]),
         .o_result        (res_w[g]),
         .o_err_cnt       (errc_w[g]),
         .o_first_err_idx (fidx_w[g])
      );
      // Cell under test: output is its truth table looked up by {a,b}
      assign c_w[g] = tt[g][{a_w[g], b_w[g]}];
   end

   function automatic int settle_of(input int g);
      return (g == 0) ? 2 : 1;
   endfunction

   // Reference: what a sweep over truth table t must report
   function automatic exp_t model(input logic [3:0] t, input int sc);
      exp_t       e;
      logic [3:0] m;
      m           = t ^ EXP;
      e.start_cyc = sc;
      e.res       = t;
      e.err       = $countones(m);
      e.first     = 0;
      for (int i = 3; i >= 0; i--) if (m[i]) e.first = i;
      e.pass      = (e.err == 0);
      return e;
   endfunction

   task automatic chk(input string name, input int g, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s inst%0d cyc=%0d actual=%0d required=%0d", name, g, cyc, act, req);
      end
   endtask

   // Monitor: grades each instance against the oldest outstanding expected sweep
   always @(negedge clk) begin
      for (int g = 0; g < 2; g++) begin
         exp_t it;
         bit   have;
         int   k;
         int   per;
         int   lat;
         per  = settle_of(g) + 1;
         lat  = 4 * per + 1;
         have = 1'b0;
         if (rst) begin
            chk("rst_busy", g, int'(busy_w[g]), 0);
            chk("rst_done", g, int'(done_w[g]), 0);
            chk("rst_pass", g, int'(pass_w[g]), 0);
            chk("rst_ab",   g, int'({a_w[g], b_w[g]}), 0);
            chk("rst_res",  g, int'(res_w[g]), 0);
            chk("rst_errc", g, int'(errc_w[g]), 0);
            chk("rst_fidx", g, int'(fidx_w[g]), 0);
            if (g == 0) rd0 = q0.size();
            else        rd1 = q1.size();
         end else begin
            if (g == 0 && rd0 < q0.size()) begin it = q0[rd0]; have = 1'b1; end
            if (g == 1 && rd1 < q1.size()) begin it = q1[rd1]; have = 1'b1; end
            if (have) begin
               k = cyc - it.start_cyc;
               if (k == 0) begin
                  chk("clr_res",  g, int'(res_w[g]), 0);
                  chk("clr_errc", g, int'(errc_w[g]), 0);
                  chk("clr_fidx", g, int'(fidx_w[g]), 0);
               end
               if (k >= 0 && k < lat) chk("done_low", g, int'(done_w[g]), 0);
               if (k >= 0 && k < 4 * per) begin
                  chk("busy", g, int'(busy_w[g]), 1);
                  chk("vector", g, int'({a_w[g], b_w[g]}), k / per);
               end
               if (k == 4 * per) chk("busy_end", g, int'(busy_w[g]), 0);
               if (k == lat) begin
                  chk("done_edge", g, int'(done_w[g]), 1);
                  chk("result",    g, int'(res_w[g]), int'(it.res));
                  chk("err_cnt",   g, int'(errc_w[g]), it.err);
                  chk("first_err", g, int'(fidx_w[g]), it.first);
                  chk("pass",      g, int'(pass_w[g]), int'(it.pass));
                  chk("hold_ab",   g, int'({a_w[g], b_w[g]}), 3);
                  if (g == 0) rd0 = rd0 + 1;
                  else        rd1 = rd1 + 1;
               end
            end else if (done_w[g] && !prev_done[g]) begin
               chk("spurious_done", g, 1, 0);
            end
         end
         prev_done[g] = done_w[g];
      end
   end

   // Pulse start for one cycle; optionally queue the sweep each instance should report
   task automatic do_start(input bit record);
      @(negedge clk);
      start = 1'b1;
      if (record) begin
         q0.push_back(model(tt[0], cyc + 1));
         q1.push_back(model(tt[1], cyc + 1));
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      tt[0] = 4'b1011;
      tt[1] = 4'b1011;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;

      // Correct implication cells
      do_start(1'b1);
      repeat (16) @(negedge clk);

      // Stuck-at-1 / stuck-at-0, then swapped between instances
      tt[0] = 4'b1111; tt[1] = 4'b0000;
      do_start(1'b1);
      repeat (16) @(negedge clk);
      tt[0] = 4'b0000; tt[1] = 4'b1111;
      do_start(1'b1);
      repeat (16) @(negedge clk);

      // Start pulsed mid-sweep is ignored; then restart from DONE
      tt[0] = 4'b1011; tt[1] = 4'b1011;
      do_start(1'b1);
      repeat (4) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      do_start(1'b1);
      repeat (16) @(negedge clk);

      // Asynchronous reset between edges aborts the sweep; no done may follow
      tt[0] = 4'b0110; tt[1] = 4'b1001;
      do_start(1'b1);
      repeat (6) @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (20) @(negedge clk);

      // Random cell functions
      for (int n = 0; n < 24; n++) begin
         tt[0] = 4'($urandom());
         tt[1] = 4'($urandom());
         do_start(1'b1);
         repeat (14 + $urandom_range(0, 3)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
